// File: rtl/fb_pkg.sv
// Shared constants, types and address helper for the cell framebuffer port arbiter.
package fb_pkg;

    localparam int FB_W      = 100;
    localparam int FB_H      = 75;
    localparam int CELL_LOG2 = 3;
    localparam int COLOR_W   = 3;
    localparam int ADDR_W    = 13;
    localparam int FB_CELLS  = FB_W * FB_H;

    // Cell colours, bit order {R,G,B}.
    localparam logic [COLOR_W-1:0] C_BLACK   = 3'b000;
    localparam logic [COLOR_W-1:0] C_BLUE    = 3'b001;
    localparam logic [COLOR_W-1:0] C_GREEN   = 3'b010;
    localparam logic [COLOR_W-1:0] C_CYAN    = 3'b011;
    localparam logic [COLOR_W-1:0] C_RED     = 3'b100;
    localparam logic [COLOR_W-1:0] C_MAGENTA = 3'b101;
    localparam logic [COLOR_W-1:0] C_YELLOW  = 3'b110;
    localparam logic [COLOR_W-1:0] C_WHITE   = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        CLR  = 1'b1
    } fb_state_e;

    // Linear cell index for a pixel coordinate: row*FB_W + col, truncated to ADDR_W.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] x, input logic [9:0] y);
        return ADDR_W'((20'(y >> CELL_LOG2) * 20'(FB_W)) + 20'(x >> CELL_LOG2));
    endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Writer handshake and framebuffer RAM port bundle.
// master: drawing side / RAM model; slave: the port arbiter.
interface fb_port_arbiter_if;
    import fb_pkg::*;

    logic [1:0]         wr_req;
    logic [ADDR_W-1:0]  wr_addr0;
    logic [ADDR_W-1:0]  wr_addr1;
    logic [COLOR_W-1:0] wr_data0;
    logic [COLOR_W-1:0] wr_data1;
    logic [1:0]         wr_gnt;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic [COLOR_W-1:0] mem_wdata;
    logic [COLOR_W-1:0] mem_rdata;

    modport master (
        output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1, mem_rdata,
        input  wr_gnt, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1, mem_rdata,
        output wr_gnt, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/fb_rr_arb2.sv
// Two-way writer arbiter producing a one-hot grant from the eligible mask.
// Optional macro FB_ARB_FIXED_PRIO_EN: writer 0 always wins, no pointer state.
module fb_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] eligible,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef FB_ARB_FIXED_PRIO_EN
    logic unused_s;
    assign unused_s = &{1'b0, clk, rst_n, advance};

    // Fixed priority: writer 0 first, writer 1 only when writer 0 is not eligible.
    always_comb begin
        grant = 2'b00;
        if (eligible[0]) begin
            grant = 2'b01;
        end else if (eligible[1]) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end
`else
    // prio_q==0 favours writer 0 when both are eligible.
    logic prio_q;
    logic prio_d;

    // One-hot grant; contention resolved by the pointer.
    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer favours the writer not served by the last consumed grant.
    always_comb begin
        prio_d = prio_q;
        if (advance && grant[0]) begin
            prio_d = 1'b1;
        end else if (advance && grant[1]) begin
            prio_d = 1'b0;
        end else begin
            prio_d = prio_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer owner: scan-out reads have absolute priority, free
// slots go to the clear engine (when sweeping) or to two arbitrated writers.
// Optional macro FB_ARB_FIXED_PRIO_EN selects fixed writer priority (see fb_rr_arb2).
module fb_port_arbiter
    import fb_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [9:0]         x_coord,
    input  logic [9:0]         y_coord,
    input  logic               blank,
    output logic [COLOR_W-1:0] pix_color,
    input  logic               clr_start,
    input  logic [COLOR_W-1:0] clr_color,
    output logic               clr_busy,
    fb_port_arbiter_if.slave   port_if
);

    localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(FB_CELLS);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(FB_CELLS - 1);

    fb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [COLOR_W-1:0] clr_col_q, clr_col_d;
    logic               clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_we_q, mem_we_d;
    logic [COLOR_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]         wr_gnt_q, wr_gnt_d;
    logic               scan_p1_q, scan_p2_q;
    logic               blank_p1_q, blank_p2_q;
    logic [COLOR_W-1:0] pix_q, pix_d;

    logic               scan_slot_s;
    logic [ADDR_W-1:0]  scan_addr_s;
    logic [1:0]         eligible_s;
    logic [1:0]         grant_s;
    logic               advance_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [COLOR_W-1:0] sel_data_s;

    assign scan_slot_s = !blank && (x_coord[CELL_LOG2-1:0] == 3'd0);
    assign scan_addr_s = cell_addr(x_coord, y_coord);
    // A writer whose grant is visible this cycle may not be granted again.
    assign eligible_s  = port_if.wr_req & ~wr_gnt_q;
    assign advance_s   = !scan_slot_s && (state_q == IDLE);
    assign sel_addr_s  = grant_s[1] ? port_if.wr_addr1 : port_if.wr_addr0;
    assign sel_data_s  = grant_s[1] ? port_if.wr_data1 : port_if.wr_data0;

    fb_rr_arb2 u_arb (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .eligible (eligible_s),
        .advance  (advance_s),
        .grant    (grant_s)
    );

    // Clear-engine FSM: start only from IDLE, finish after writing the last cell.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_col_d = clr_col_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d   = CLR;
                    cnt_d     = {ADDR_W{1'b0}};
                    clr_col_d = clr_color;
                end else begin
                    state_d = IDLE;
                end
            end
            CLR: begin
                if (scan_slot_s) begin
                    state_d = CLR;
                end else if (cnt_q == LAST_A) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 13'd1;
                end else begin
                    state_d = CLR;
                    cnt_d   = cnt_q + 13'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        clr_busy_d = (state_d == CLR);
    end

    // RAM port usage for the next cycle: scan read, clear write or writer grant.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_gnt_d    = 2'b00;
        if (scan_slot_s) begin
            mem_addr_d = scan_addr_s;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_s != 2'b00) begin
                        wr_gnt_d    = grant_s;
                        mem_addr_d  = sel_addr_s;
                        mem_wdata_d = sel_data_s;
                        // Out-of-range writes are consumed but dropped.
                        mem_we_d    = (sel_addr_s < CELLS_A);
                    end else begin
                        wr_gnt_d = 2'b00;
                    end
                end
                CLR: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = clr_col_q;
                end
                default: begin
                    mem_we_d = 1'b0;
                end
            endcase
        end
    end

    // Pixel output: capture read data two edges after a scan slot, black while blanked.
    always_comb begin
        pix_d = pix_q;
        if (blank_p2_q) begin
            pix_d = C_BLACK;
        end else if (scan_p2_q) begin
            pix_d = port_if.mem_rdata;
        end else begin
            pix_d = pix_q;
        end
    end

    // State, port and pipeline registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {ADDR_W{1'b0}};
            clr_col_q   <= {COLOR_W{1'b0}};
            clr_busy_q  <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_we_q    <= 1'b0;
            mem_wdata_q <= {COLOR_W{1'b0}};
            wr_gnt_q    <= 2'b00;
            scan_p1_q   <= 1'b0;
            scan_p2_q   <= 1'b0;
            blank_p1_q  <= 1'b0;
            blank_p2_q  <= 1'b0;
            pix_q       <= {COLOR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_col_q   <= clr_col_d;
            clr_busy_q  <= clr_busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wr_gnt_q    <= wr_gnt_d;
            scan_p1_q   <= scan_slot_s;
            scan_p2_q   <= scan_p1_q;
            blank_p1_q  <= blank;
            blank_p2_q  <= blank_p1_q;
            pix_q       <= pix_d;
        end
    end

    assign pix_color         = pix_q;
    assign clr_busy          = clr_busy_q;
    assign port_if.mem_addr  = mem_addr_q;
    assign port_if.mem_we    = mem_we_q;
    assign port_if.mem_wdata = mem_wdata_q;
    assign port_if.wr_gnt    = wr_gnt_q;

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
Owns the single port of the cell-based framebuffer RAM (100x75 cells, each cell 8x8 pixels, COLOR_W bits per cell). Scan-out reads from the hsync/vsync coordinates take absolute priority. Two writer requesters share the remaining slots round-robin, and a built-in clear engine can sweep the whole buffer. Sits between hsync/vsync, the drawing logic and color_out; pix_color feeds color_out.

Parameters:
FB_W, 100, framebuffer width in cells
FB_H, 75, framebuffer height in cells
CELL_LOG2, 3, log2 of cell edge in pixels
COLOR_W, 3, bits per cell (R,G,B)
ADDR_W, 13, linear cell address width (FB_W*FB_H <= 2^ADDR_W)

Ports:
sys_clk  in  1  system/pixel clock
sys_rst_n  in  1  asynchronous active-low reset
x_coord  in  10  pixel x from hsync (all-ones when blanked)
y_coord  in  10  pixel y from vsync (all-ones when blanked)
blank  in  1  hblank OR vblank
pix_color  out  COLOR_W  cell color for color_out, 2-cycle latency
wr_req  in  2  per-writer request, held until granted
wr_addr0 / wr_addr1  in  ADDR_W  linear cell address (row*FB_W+col)
wr_data0 / wr_data1  in  COLOR_W  write data
wr_gnt  out  2  one-cycle pulse: the request was consumed
clr_start  in  1  pulse: start a full-buffer clear
clr_color  in  COLOR_W  fill value, sampled at clr_start
clr_busy  out  1  clear in progress
mem_addr  out  ADDR_W  RAM address (registered)
mem_we  out  1  RAM write enable (registered)
mem_wdata  out  COLOR_W  RAM write data (registered)
mem_rdata  in  COLOR_W  RAM synchronous read data, valid 1 cycle after mem_addr

Behaviour:
- Reset (async, sys_rst_n=0): all outputs 0, FSM=IDLE, clear counter 0, round-robin pointer favours writer 0, internal pipes cleared. A reset during a clear aborts it; no resume.
- Slot classification is evaluated every edge from the sampled inputs. Scan slot: blank==0 and x_coord[CELL_LOG2-1:0]==0. Every other cycle is a free slot.
- Scan slot: mem_addr <= (y_coord>>CELL_LOG2)*FB_W + (x_coord>>CELL_LOG2); mem_we <= 0; no grant. Capture mem_rdata into pix_color 2 edges later and hold it until the next capture. pix_color is forced to 0 whenever blank delayed by 2 cycles is 1. The top level delays HSync/VSync/blank by 2 to align.
- FSM states:
  - IDLE: writers are served in free slots. clr_start=1 -> CLR; latch clr_color; counter=0; clr_busy=1 from the next cycle.
  - CLR: in each free slot, mem_we=1, mem_addr=counter, mem_wdata=latched color, counter+1. After the write to FB_W*FB_H-1 -> IDLE, and clr_busy falls the same edge. Writers receive no grants in CLR. clr_start is ignored in CLR.
- Writer arbitration (IDLE, free slot):
  - Eligible = wr_req[i] and not wr_gnt[i]. This blocks a double grant in the cycle a requester sees its grant.
  - One eligible: grant it. Both eligible: grant the one not granted last; pointer updates on every grant.
  - Granted writer: mem_we <= 1, mem_addr/mem_wdata <= its inputs, wr_gnt[i] <= 1 for exactly one cycle.
- Address bounds: a granted write with addr >= FB_W*FB_H still pulses wr_gnt but drives mem_we=0 (dropped).
- Simultaneous clr_start and wr_req in IDLE: the writer is granted this slot if it is free; CLR takes effect from the next edge.
- Address math: unsigned; row*FB_W uses a constant multiply, truncated to ADDR_W. Coordinates are never used when blank=1.

Optional Feature:
FB_ARB_FIXED_PRIO_EN: when defined, writer 0 always wins over writer 1 and the round-robin pointer is removed. The double-grant block still applies, so writer 1 is served in the cycle after a writer-0 grant. When undefined, round-robin as above.

Decomposition:
- Package fb_pkg: FB_W, FB_H, CELL_LOG2, FB_CELLS, ADDR_W, color constants C_BLACK..C_WHITE, FSM state enum {IDLE, CLR}.
- Sub-module fb_rr_arb2: 2-way round-robin arbiter taking eligible[1:0] and advance, producing a one-hot grant. The fixed-priority macro lives inside it.

Test Plan:
- Reset: hold sys_rst_n=0 with wr_req=2'b11 and clr_start=1 -> mem_we=0, wr_gnt=0, pix_color=0, clr_busy=0. Release -> first grant goes to writer 0.
- Scan priority: blank=0, x=8, y=16, wr_req=2'b01 -> mem_addr=201, mem_we=0, wr_gnt=0. Next cycle x=9 -> mem_we=1, mem_addr=wr_addr0, wr_gnt=2'b01.
- Read latency: mem_rdata=3'b101 one cycle after the scan address -> pix_color=3'b101 2 cycles after x=8 was sampled, held through x=15. blank=1 -> pix_color=0 after 2 cycles.
- Round-robin: blank=1, wr_req=2'b11 held -> wr_gnt sequence 01,10,01,10. With FB_ARB_FIXED_PRIO_EN the sequence is also 01,10,01,10, and writer 1 never wins while writer 0 is eligible.
- Clear: blank=1, clr_start with clr_color=3'b111 -> 7500 writes to addresses 0..7499, all data 3'b111, wr_gnt stays 0, clr_busy low after the last write. Repeat with blank=0 -> scan slots are never written.
- Bounds: wr_addr1=7500, wr_req=2'b10 -> wr_gnt=2'b10 for one cycle, mem_we stays 0.
